// File: rtl/sdf_distance_if.sv
// Distance-query handshake between the ray marcher (master) and the SDF engine (slave).
// pos packs {x, y, z}, each Q8.24 signed, with x in the top 32 bits.
interface sdf_distance_if;
  logic        valid_in;
  logic [95:0] pos;
  logic        obj_sel;
  logic [31:0] closest_dist;
  logic        valid_out;
  logic        busy;

  modport master (output valid_in, pos, obj_sel, input closest_dist, valid_out, busy);
  modport slave  (input valid_in, pos, obj_sel, output closest_dist, valid_out, busy);
endinterface

// File: rtl/sdf_distance_eval.sv
// Signed distance from a query point to a sphere or an axis-aligned box, Q8.24, with a
// fixed 36-cycle latency. The vector length comes from a bit-serial integer square root.
//
// state  | meaning
// IDLE   | waiting for a query strobe
// PREP   | offset from centre, |q|, box slab distances
// SQUARE | three 32x32 squares
// SUM    | sum of squares, loads the square-root engine
// SQRT   | one root bit per cycle, MSB first, cnt 31..0
// FINISH | combine length with radius / box interior term
module sdf_distance_eval #(
  parameter logic [31:0] SPH_CX = 32'h0000_0000,
  parameter logic [31:0] SPH_CY = 32'h0000_0000,
  parameter logic [31:0] SPH_CZ = 32'h0300_0000,
  parameter logic [31:0] SPH_R  = 32'h0100_0000,
  parameter logic [31:0] BOX_CX = 32'h0000_0000,
  parameter logic [31:0] BOX_CY = 32'h0000_0000,
  parameter logic [31:0] BOX_CZ = 32'h0300_0000,
  parameter logic [31:0] BOX_HX = 32'h0080_0000,
  parameter logic [31:0] BOX_HY = 32'h0080_0000,
  parameter logic [31:0] BOX_HZ = 32'h0080_0000
) (
  input  logic          clk,
  input  logic          rst,
  sdf_distance_if.slave q_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_SQUARE, S_SUM, S_SQRT, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [2:0][31:0] pos_q, pos_d;
  logic             obj_q, obj_d;
  logic [2:0][31:0] e_q, e_d;
  logic [31:0]      m_q, m_d;
  logic [2:0][63:0] prod_q, prod_d;
  logic [63:0]      rad_q, rad_d;
  logic [32:0]      rem_q, rem_d;
  logic [31:0]      root_q, root_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      dist_q, dist_d;
  logic             vout_q, vout_d;

  logic [2:0][31:0] cen, half, a_v, e_prep;
  logic [2:0][32:0] d_v;
  logic [32:0]      dmax;
  logic [31:0]      m_prep;
  logic [65:0]      sum66;
  logic [34:0]      rem_sh, trial;
  logic [31:0]      len;

  function automatic logic [31:0] sat32(input logic [32:0] v);
    if (v[32] != v[31]) return v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return v[31:0];
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    if (v == 32'h8000_0000) return 32'h7FFF_FFFF;
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Offset, magnitude and box slab distances, evaluated from the captured query.
  always_comb begin
    cen    = obj_q ? {BOX_CX, BOX_CY, BOX_CZ} : {SPH_CX, SPH_CY, SPH_CZ};
    half   = {BOX_HX, BOX_HY, BOX_HZ};
    a_v    = '0;
    d_v    = '0;
    e_prep = '0;
    for (int i = 0; i < 3; i++) begin
      a_v[i]    = abs32(sat32({pos_q[i][31], pos_q[i]} - {cen[i][31], cen[i]}));
      d_v[i]    = {1'b0, a_v[i]} - {half[i][31], half[i]};
      e_prep[i] = obj_q ? (d_v[i][32] ? 32'h0 : sat32(d_v[i])) : a_v[i];
    end
    dmax = d_v[2];
    if ($signed(d_v[1]) > $signed(dmax)) dmax = d_v[1];
    if ($signed(d_v[0]) > $signed(dmax)) dmax = d_v[0];
    m_prep = dmax[32] ? sat32(dmax) : 32'h0;
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    obj_d   = obj_q;
    e_d     = e_q;
    m_d     = m_q;
    prod_d  = prod_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    vout_d  = 1'b0;
    sum66   = '0;
    rem_sh  = '0;
    trial   = '0;
    len     = '0;
    case (state_q)
      S_PREP: begin
        e_d     = e_prep;
        m_d     = m_prep;
        state_d = S_SQUARE;
      end
      S_SQUARE: begin
        for (int i = 0; i < 3; i++) prod_d[i] = 64'(e_q[i]) * 64'(e_q[i]);
        state_d = S_SUM;
      end
      S_SUM: begin
        sum66   = {2'b00, prod_q[0]} + {2'b00, prod_q[1]} + {2'b00, prod_q[2]};
        rad_d   = (sum66[65:64] != 2'b00) ? '1 : sum66[63:0];
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = 5'd31;
        state_d = S_SQRT;
      end
      S_SQRT: begin
        // Restoring square root: bring down two radicand bits, try root*4+1.
        rem_sh = {rem_q, rad_q[63:62]};
        trial  = {1'b0, root_q, 2'b01};
        rad_d  = {rad_q[61:0], 2'b00};
        if (rem_sh >= trial) begin
          rem_d  = rem_sh[32:0] - trial[32:0];
          root_d = {root_q[30:0], 1'b1};
        end else begin
          rem_d  = rem_sh[32:0];
          root_d = {root_q[30:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_FINISH;
      end
      S_FINISH: begin
        len     = root_q[31] ? 32'h7FFF_FFFF : root_q;
        dist_d  = obj_q ? sat32({len[31], len} + {m_q[31], m_q})
                        : sat32({len[31], len} - {SPH_R[31], SPH_R});
        vout_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase
    // A new strobe always wins: it aborts whatever is in flight and restarts.
    if (q_if.valid_in) begin
      pos_d   = q_if.pos;
      obj_d   = q_if.obj_sel;
      state_d = S_PREP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_q  <= '0;
      obj_q  <= 1'b0;
      e_q    <= '0;
      m_q    <= '0;
      prod_q <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      dist_q <= '0;
      vout_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      obj_q  <= obj_d;
      e_q    <= e_d;
      m_q    <= m_d;
      prod_q <= prod_d;
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      dist_q <= dist_d;
      vout_q <= vout_d;
    end
  end

  assign q_if.closest_dist = dist_q;
  assign q_if.valid_out    = vout_q;
  assign q_if.busy         = (state_q != S_IDLE) && (state_q != S_FINISH);

endmodule

// File: tb/tb_sdf_distance_eval.sv
// Directed checks of sdf_distance_eval: reset, sphere/box distances, latency, restart,
// abort by reset, saturation and back-to-back queries.
module tb_sdf_distance_eval;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  sdf_distance_if dif ();

  sdf_distance_eval dut (
    .clk  (clk),
    .rst  (rst),
    .q_if (dif)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] F0   = 32'h0000_0000;
  localparam logic [31:0] F1P5 = 32'h0180_0000;
  localparam logic [31:0] F3   = 32'h0300_0000;
  localparam logic [31:0] FMIN = 32'h8000_0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [95:0] p, input logic sel);
    dif.valid_in = 1'b1;
    dif.pos      = p;
    dif.obj_sel  = sel;
    tick();
    dif.valid_in = 1'b0;
    dif.pos      = {3{32'hDEAD_BEEF}};
    dif.obj_sel  = ~sel;
  endtask

  // Called just after the sampling edge; returns on the valid_out cycle.
  task automatic wait_result(input string tag, input logic [31:0] exp);
    int lat = 0;
    do begin
      tick();
      lat++;
    end while (!dif.valid_out && lat < 60);
    chk({tag, "_lat"}, 32'(lat), 32'd36);
    chk({tag, "_dist"}, dif.closest_dist, exp);
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (dif.valid_out) n++;
    end
  endtask

  initial begin
    int n;
    dif.valid_in = 1'b0;
    dif.pos      = '0;
    dif.obj_sel  = 1'b0;

    // Reset held three cycles while strobes arrive.
    for (int i = 0; i < 3; i++) begin
      dif.valid_in = (i != 1);
      dif.pos      = {F0, F0, F0};
      tick();
      chk("rst_dist", dif.closest_dist, 32'h0);
      chk("rst_vout", {31'b0, dif.valid_out}, 32'h0);
      chk("rst_busy", {31'b0, dif.busy}, 32'h0);
    end
    dif.valid_in = 1'b0;
    rst = 1'b1;
    tick();

    strobe({F0, F0, F0}, 1'b0);
    chk("sph0_busy", {31'b0, dif.busy}, 32'h1);
    wait_result("sph0", 32'h0200_0000);
    chk("sph0_busy_done", {31'b0, dif.busy}, 32'h0);
    tick();
    chk("sph0_pulse_w", {31'b0, dif.valid_out}, 32'h0);
    chk("sph0_hold", dif.closest_dist, 32'h0200_0000);

    strobe({F0, F0, F3}, 1'b0);
    wait_result("sph_in", 32'hFF00_0000);
    strobe({F0, F0, F3}, 1'b1);
    wait_result("box_in", 32'hFF80_0000);
    strobe({F1P5, F0, F3}, 1'b1);
    wait_result("box_x", 32'h0100_0000);
    strobe({F1P5, F1P5, F3}, 1'b1);
    wait_result("box_xy", 32'h016A_09E6);

    // Restart: the first query must never report.
    strobe({F0, F0, F0}, 1'b0);
    for (int k = 0; k < 9; k++) tick();
    strobe({F0, F0, F3}, 1'b1);
    wait_result("restart", 32'hFF80_0000);
    count_pulses(40, n);
    chk("restart_extra", 32'(n), 32'd0);

    // Reset in the middle of the square root aborts the query.
    strobe({F0, F0, F0}, 1'b0);
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b0;
    tick();
    chk("abort_busy", {31'b0, dif.busy}, 32'h0);
    chk("abort_dist", dif.closest_dist, 32'h0);
    rst = 1'b1;
    count_pulses(45, n);
    chk("abort_pulses", 32'(n), 32'd0);

    // Saturation, then queries issued on each valid_out cycle.
    strobe({FMIN, FMIN, FMIN}, 1'b0);
    wait_result("sat", 32'h7EFF_FFFF);
    strobe({F1P5, F1P5, F3}, 1'b1);
    wait_result("b2b_box", 32'h016A_09E6);
    strobe({F0, F0, F0}, 1'b0);
    wait_result("b2b_sph", 32'h0200_0000);

    // Strobe landing in the FINISH cycle: pulse still appears, new query follows.
    strobe({F0, F0, F3}, 1'b0);
    for (int k = 0; k < 35; k++) tick();
    chk("fin_pre", {31'b0, dif.valid_out}, 32'h0);
    strobe({F0, F0, F3}, 1'b1);
    chk("fin_vout", {31'b0, dif.valid_out}, 32'h1);
    chk("fin_dist", dif.closest_dist, 32'hFF00_0000);
    wait_result("fin_next", 32'hFF80_0000);
    tick();
    chk("fin_end", {31'b0, dif.valid_out}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
